module_codificador_hamming_tx: RTL

Transmit-side end of the team's Hamming SECDED link. It accepts a 4-bit data nibble over a valid/ready handshake and encodes it into the 8-bit SECDED codeword that the receive-side corrector expects. It can XOR a per-word error-injection mask into the codeword, then serializes the codeword onto a single-wire frame (start, 8 bits LSB first, stop). It sits between the data source/switches and the serial link feeding the receiver/corrector path.

---
 rtl/module_codificador_hamming_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/module_codificador_hamming_tx.sv
// module_codificador_hamming_tx
// Transmit end of the Hamming SECDED link. This block takes in a 4-bit data
// nibble through a valid/ready handshake. It encodes the nibble into an 8-bit
// SECDED codeword and can XOR an error-injection mask into that codeword. It
// then sends the codeword on one serial wire as a frame: a start bit (0), the
// 8 codeword bits LSB first, and a stop bit (1). Each bit lasts BAUD_DIV clocks.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   datos_in[3:0]       data nibble d[3:0], sampled only at accept
//   valid_in            datos_in / mascara_error are valid
//   mascara_error[7:0]  error-injection mask, XORed into the codeword at accept
//   ready_out           block can accept a word (high only in IDLE)
//   palabra_codificada  registered transmitted codeword (after injection)
//   tx_serial           serial line, idles high
//   busy                a frame is in progress
//   done                one-cycle pulse in the cycle the FSM returns to IDLE
module module_codificador_hamming_tx #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] datos_in,
  input  logic       valid_in,
  input  logic [7:0] mascara_error,
  output logic       ready_out,
  output logic [7:0] palabra_codificada,
  output logic       tx_serial,
  output logic       busy,
  output logic       done
);

  // BAUD_DIV=1 would give a zero-width counter, so keep at least one bit.
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic [7:0]    word_q, word_d;

  logic          bit_wrap;
  logic [2:0]    idx_inc;

  // SECDED encoder. Bit index is the Hamming position minus 1. The overall
  // parity bit p0 sits in b7 and gives even parity over the whole byte.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[7] = ^c[6:0];
    return c;
  endfunction

  assign bit_wrap = (cnt_q == CNT_LAST);
  assign idx_inc  = idx_q + 3'd1;

  // Next-state logic. tx_d is worked out together with the state, so the line
  // level changes on the same edge as the state transition. The baud counter
  // goes back to zero on every bit boundary, so the first cycle of every bit
  // always sees a count of 0. The exception is a wrap in STOP: there the
  // counter stays at 0 and the state goes to IDLE. That is also why BAUD_DIV=1
  // works with no special case: bit_wrap is then true on every cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    word_d  = word_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (valid_in) begin
          word_d  = encode(datos_in) ^ mascara_error;
          state_d = START;
          cnt_d   = '0;
          idx_d   = 3'd0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_wrap) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = DATA;
          tx_d    = word_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_wrap) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_inc;
            tx_d  = word_q[idx_inc];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_wrap) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers. Reset drives the line to its idle-high
  // level, so asserting reset in the middle of a frame never pulls it low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      word_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      word_q  <= word_d;
    end
  end

  assign ready_out          = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign tx_serial          = tx_q;
  assign palabra_codificada = word_q;

endmodule
